// File: rtl/mem_stage_if.sv
// EX -> MEM -> WB valid/allowin handshake and payload buses around the MEM stage.
interface mem_stage_if #(
  parameter int unsigned ES2MS_W = 86,
  parameter int unsigned MS2WS_W = 77
);
  logic               es_to_ms_valid;
  logic [ES2MS_W-1:0] es_to_ms_bus;
  logic               ms_allowin;
  logic               ms_to_ws_valid;
  logic [MS2WS_W-1:0] ms_to_ws_bus;
  logic               ws_allowin;

  // master = surrounding pipeline (EX producer, WB consumer); slave = MEM stage
  modport master (
    output es_to_ms_valid, es_to_ms_bus, ws_allowin,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus
  );

  modport slave (
    input  es_to_ms_valid, es_to_ms_bus, ws_allowin,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus
  );
endinterface

// File: rtl/mem_stage.sv
// MEM stage: holds the EX bundle until its data-SRAM response arrives, aligns/extends
// load data, forwards the result to WB and exports a forwarding bundle to ID.
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  mem_stage_if.slave  pipe,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        flush,
  output logic [38:0] ms_rf_collect,
  output logic        ms_has_except
);
  localparam int unsigned ES2MS_W = 86;
  localparam int unsigned MS2WS_W = 77;
  localparam int unsigned EXC_W   = 7;

  logic               ms_valid;
  logic [ES2MS_W-1:0] es_bus_r;
  logic [31:0]        rdata_buf;
  logic               rdata_buf_valid;
  logic               discard;

  logic [31:0]      ms_pc;
  logic             ms_rf_we;
  logic [4:0]       ms_rf_waddr;
  logic             ms_res_from_mem;
  logic             ms_mem_req;
  logic [4:0]       ms_ld_op;
  logic [1:0]       ms_addr_lo;
  logic [31:0]      ms_ex_result;
  logic [EXC_W-1:0] ms_except;

  assign {ms_pc, ms_rf_we, ms_rf_waddr, ms_res_from_mem, ms_mem_req,
          ms_ld_op, ms_addr_lo, ms_ex_result, ms_except} = es_bus_r;

  logic data_ok_live;
  logic ms_ready_go;
  logic allowin;
  logic to_ws_valid;

  // A response arriving while discard is set belongs to a flushed request
  assign data_ok_live = data_sram_data_ok & ~discard;
  assign ms_ready_go  = ~ms_mem_req | rdata_buf_valid | data_ok_live;
  assign allowin      = ~ms_valid | (ms_ready_go & pipe.ws_allowin);
  assign to_ws_valid  = ms_valid & ms_ready_go & ~flush;

  logic [31:0] load_sel;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic [31:0] final_result;

  always_comb begin
    load_sel  = rdata_buf_valid ? rdata_buf : data_sram_rdata;
    load_byte = load_sel[{ms_addr_lo, 3'b000} +: 8];
    load_half = load_sel[{ms_addr_lo[1], 4'b0000} +: 16];
    case (ms_ld_op)
      5'b10000: load_data = {{24{load_byte[7]}}, load_byte};
      5'b01000: load_data = {24'h0, load_byte};
      5'b00100: load_data = {{16{load_half[15]}}, load_half};
      5'b00010: load_data = {16'h0, load_half};
      default:  load_data = load_sel;
    endcase
    final_result = ms_res_from_mem ? load_data : ms_ex_result;
  end

  // Pipeline valid and bundle latch; flush kills the resident bundle and blocks entry
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid <= 1'b0;
      es_bus_r <= '0;
    end else begin
      if (flush) begin
        ms_valid <= 1'b0;
      end else if (allowin) begin
        ms_valid <= pipe.es_to_ms_valid;
      end
      if (pipe.es_to_ms_valid && allowin && !flush) begin
        es_bus_r <= pipe.es_to_ms_bus;
      end
    end
  end

  // Hold load data that arrived while WB was stalled
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_buf_valid <= 1'b0;
      rdata_buf       <= '0;
    end else if (flush || (to_ws_valid && pipe.ws_allowin)) begin
      rdata_buf_valid <= 1'b0;
    end else if (data_ok_live && ms_valid && !pipe.ws_allowin) begin
      rdata_buf_valid <= 1'b1;
      rdata_buf       <= data_sram_rdata;
    end
  end

  // Remember to drop the response of a request killed before its data came back
  always_ff @(posedge clk) begin
    if (!resetn) begin
      discard <= 1'b0;
    end else if (flush && ms_valid && ms_mem_req && !rdata_buf_valid && !data_sram_data_ok) begin
      discard <= 1'b1;
    end else if (data_sram_data_ok) begin
      discard <= 1'b0;
    end
  end

  logic [MS2WS_W-1:0] ws_bus;
  assign ws_bus = {ms_pc, ms_rf_we, ms_rf_waddr, final_result, ms_except};

  assign pipe.ms_allowin     = allowin;
  assign pipe.ms_to_ws_valid = to_ws_valid;
  assign pipe.ms_to_ws_bus   = ws_bus;

  assign ms_rf_collect = {ms_valid & ms_res_from_mem & ~ms_ready_go,
                          ms_valid & ms_rf_we,
                          ms_valid ? ms_rf_waddr : 5'd0,
                          ms_valid ? final_result : 32'd0};
  assign ms_has_except = ms_valid & (|ms_except);
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed load/flush/stall sequences, a load-extension vector
// table, and a randomized run against a transaction-level model of the stage.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        resetn;
  logic        data_ok;
  logic [31:0] rdata;
  logic        flush;
  logic [38:0] collect;
  logic        has_exc;

  int n_cmp = 0;
  int n_err = 0;

  mem_stage_if ifc ();

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .pipe              (ifc.slave),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata),
    .flush             (flush),
    .ms_rf_collect     (collect),
    .ms_has_except     (has_exc)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] LD_B = 5'b10000, LD_BU = 5'b01000, LD_H = 5'b00100,
                         LD_HU = 5'b00010, LD_W = 5'b00001;

  typedef struct {
    logic [4:0]  op;
    logic [1:0]  al;
    logic [31:0] word;
    logic [31:0] want;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  wa;
    logic        rfm;
    logic        req;
    logic [4:0]  op;
    logic [1:0]  al;
    logic [31:0] exr;
    logic [6:0]  exc;
    logic [31:0] data;
    logic        arrived;
    int          age;
  } ent_t;

  function automatic logic [85:0] mk_bus(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                                         input logic rfm, input logic req, input logic [4:0] op,
                                         input logic [1:0] al, input logic [31:0] exr, input logic [6:0] exc);
    return {pc, we, wa, rfm, req, op, al, exr, exc};
  endfunction

  function automatic logic [76:0] exp_out(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                                          input logic [31:0] fin, input logic [6:0] exc);
    return {pc, we, wa, fin, exc};
  endfunction

  // Load result from the architectural definition: pick the lane, then extend arithmetically
  function automatic logic [31:0] ref_load(input logic [4:0] op, input logic [1:0] al, input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * al)) & 32'hFF;
    h = (w >> (16 * (al / 2))) & 32'hFFFF;
    case (op)
      LD_B:    return (b >= 32'h80)   ? b - 32'h100   : b;
      LD_BU:   return b;
      LD_H:    return (h >= 32'h8000) ? h - 32'h10000 : h;
      LD_HU:   return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] final_of(input ent_t x);
    return x.rfm ? ref_load(x.op, x.al, x.data) : x.exr;
  endfunction

  task automatic rpt(input string nm, input logic [76:0] a, input logic [76:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, a, e);
    end
  endtask

  task automatic chk1(input string nm, input logic a, input logic e);
    rpt(nm, 77'(a), 77'(e));
  endtask

  task automatic chk32(input string nm, input logic [31:0] a, input logic [31:0] e);
    rpt(nm, 77'(a), 77'(e));
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic idle();
    ifc.es_to_ms_valid = 1'b0;
    ifc.es_to_ms_bus   = '0;
    ifc.ws_allowin     = 1'b1;
    data_ok            = 1'b0;
    rdata              = 32'hDEAD_BEEF;
    flush              = 1'b0;
  endtask

  task automatic enter_load(input logic [31:0] pc, input logic [4:0] wa, input logic [4:0] op, input logic [1:0] al);
    ifc.es_to_ms_valid = 1'b1;
    ifc.es_to_ms_bus   = mk_bus(pc, 1'b1, wa, 1'b1, 1'b1, op, al, 32'h0, 7'h0);
  endtask

  vec_t vecs[8];

  ent_t q[$];
  ent_t c;
  ent_t e;
  logic out_pending;
  logic owner_live;
  logic dok;
  int   out_cnt;
  logic [31:0] out_data;
  logic e_has, exp_rg, exp_v, exp_al;
  int   kind;

  initial begin
    vecs[0] = '{LD_B,  2'd3, 32'h8012_3456, 32'hFFFF_FF80};
    vecs[1] = '{LD_BU, 2'd3, 32'h8012_3456, 32'h0000_0080};
    vecs[2] = '{LD_H,  2'd2, 32'h8001_1234, 32'hFFFF_8001};
    vecs[3] = '{LD_HU, 2'd2, 32'h8001_1234, 32'h0000_8001};
    vecs[4] = '{LD_W,  2'd0, 32'h8765_4321, 32'h8765_4321};
    vecs[5] = '{LD_B,  2'd1, 32'h0000_7F00, 32'h0000_007F};
    vecs[6] = '{LD_H,  2'd0, 32'h1234_F00F, 32'hFFFF_F00F};
    vecs[7] = '{LD_BU, 2'd0, 32'h1234_56FE, 32'h0000_00FE};

    // Reset state
    resetn = 1'b0;
    idle();
    nxt(); nxt();
    #2;
    chk1("rst_valid", ifc.ms_to_ws_valid, 1'b0);
    chk1("rst_allowin", ifc.ms_allowin, 1'b1);
    rpt("rst_collect", 77'(collect), 77'(0));
    chk1("rst_has_except", has_exc, 1'b0);
    resetn = 1'b1;

    // ld_w with the response two cycles after entering MEM
    nxt(); enter_load(32'h1000, 5'd5, LD_W, 2'd0);
    #2 chk1("t1_allowin_empty", ifc.ms_allowin, 1'b1);
    nxt(); ifc.es_to_ms_valid = 1'b0;
    #2 chk1("t1_pending0", collect[38], 1'b1);
    chk1("t1_valid0", ifc.ms_to_ws_valid, 1'b0);
    nxt();
    #2 chk1("t1_pending1", collect[38], 1'b1);
    chk1("t1_allowin_wait", ifc.ms_allowin, 1'b0);
    nxt(); data_ok = 1'b1; rdata = 32'h8765_4321;
    #2 chk1("t1_valid", ifc.ms_to_ws_valid, 1'b1);
    rpt("t1_bus", ifc.ms_to_ws_bus, exp_out(32'h1000, 1'b1, 5'd5, 32'h8765_4321, 7'h0));
    chk1("t1_pending_clr", collect[38], 1'b0);
    chk32("t1_fwd", collect[31:0], 32'h8765_4321);
    nxt(); data_ok = 1'b0;
    #2 chk1("t1_gone", ifc.ms_to_ws_valid, 1'b0);

    // Load lane selection and extension table
    for (int i = 0; i < 8; i++) begin
      nxt(); data_ok = 1'b0;
      enter_load(32'h2000 + 32'(4 * i), 5'(i + 1), vecs[i].op, vecs[i].al);
      nxt(); ifc.es_to_ms_valid = 1'b0; data_ok = 1'b1; rdata = vecs[i].word;
      #2 rpt($sformatf("vec%0d_bus", i), ifc.ms_to_ws_bus,
             exp_out(32'h2000 + 32'(4 * i), 1'b1, 5'(i + 1), vecs[i].want, 7'h0));
      chk1($sformatf("vec%0d_valid", i), ifc.ms_to_ws_valid, 1'b1);
    end
    nxt(); data_ok = 1'b0;

    // Response lands while WB stalls: buffered word survives rdata changes
    nxt(); enter_load(32'h3000, 5'd7, LD_W, 2'd0);
    nxt(); ifc.es_to_ms_valid = 1'b0; data_ok = 1'b1; rdata = 32'hA5A5_0F0F; ifc.ws_allowin = 1'b0;
    #2 chk1("t3_valid_stall", ifc.ms_to_ws_valid, 1'b1);
    chk1("t3_allowin_stall", ifc.ms_allowin, 1'b0);
    for (int k = 0; k < 3; k++) begin
      nxt(); data_ok = 1'b0; rdata = $urandom;
      #2 chk32($sformatf("t3_buf_result%0d", k), ifc.ms_to_ws_bus[38:7], 32'hA5A5_0F0F);
      chk1($sformatf("t3_allowin%0d", k), ifc.ms_allowin, 1'b0);
    end
    nxt(); ifc.ws_allowin = 1'b1;
    #2 chk1("t3_allowin_go", ifc.ms_allowin, 1'b1);
    rpt("t3_bus", ifc.ms_to_ws_bus, exp_out(32'h3000, 1'b1, 5'd7, 32'hA5A5_0F0F, 7'h0));
    nxt();
    #2 chk1("t3_gone", ifc.ms_to_ws_valid, 1'b0);

    // Flush kills a waiting load; its late response must be dropped
    nxt(); enter_load(32'h4000, 5'd3, LD_W, 2'd0);
    nxt(); ifc.es_to_ms_valid = 1'b0;
    nxt(); flush = 1'b1;
    #2 chk1("t4_flush_valid", ifc.ms_to_ws_valid, 1'b0);
    nxt(); flush = 1'b0; enter_load(32'h4004, 5'd4, LD_W, 2'd0);
    #2 chk1("t4_allowin", ifc.ms_allowin, 1'b1);
    nxt(); ifc.es_to_ms_valid = 1'b0; data_ok = 1'b1; rdata = 32'h1111_1111;
    #2 chk1("t4_drop_valid", ifc.ms_to_ws_valid, 1'b0);
    chk1("t4_drop_pending", collect[38], 1'b1);
    nxt(); rdata = 32'h2222_2222;
    #2 chk1("t4_valid", ifc.ms_to_ws_valid, 1'b1);
    rpt("t4_bus", ifc.ms_to_ws_bus, exp_out(32'h4004, 1'b1, 5'd4, 32'h2222_2222, 7'h0));
    nxt(); data_ok = 1'b0;

    // Flush in the same cycle as the killed request's response: nothing left to discard
    nxt(); enter_load(32'h5000, 5'd6, LD_W, 2'd0);
    nxt(); ifc.es_to_ms_valid = 1'b0; flush = 1'b1; data_ok = 1'b1; rdata = 32'h9999_9999;
    #2 chk1("t4b_flush_valid", ifc.ms_to_ws_valid, 1'b0);
    nxt(); flush = 1'b0; data_ok = 1'b0; enter_load(32'h5004, 5'd8, LD_W, 2'd0);
    nxt(); ifc.es_to_ms_valid = 1'b0; data_ok = 1'b1; rdata = 32'h3333_3333;
    #2 rpt("t4b_bus", ifc.ms_to_ws_bus, exp_out(32'h5004, 1'b1, 5'd8, 32'h3333_3333, 7'h0));
    chk1("t4b_valid", ifc.ms_to_ws_valid, 1'b1);
    nxt(); data_ok = 1'b0;

    // Excepting bundle (ALE) passes without any memory response
    nxt(); ifc.es_to_ms_valid = 1'b1;
    ifc.es_to_ms_bus = mk_bus(32'h6000, 1'b1, 5'd9, 1'b0, 1'b0, LD_W, 2'd1, 32'hBAD0_0002, 7'h40);
    nxt(); ifc.es_to_ms_valid = 1'b0;
    #2 chk1("t5_has_except", has_exc, 1'b1);
    chk1("t5_valid", ifc.ms_to_ws_valid, 1'b1);
    rpt("t5_bus", ifc.ms_to_ws_bus, exp_out(32'h6000, 1'b1, 5'd9, 32'hBAD0_0002, 7'h40));
    nxt();
    #2 chk1("t5_has_except_clr", has_exc, 1'b0);

    // Back-to-back ALU bundles, one per cycle
    for (int i = 0; i < 5; i++) begin
      nxt();
      ifc.es_to_ms_valid = (i < 4);
      ifc.es_to_ms_bus = mk_bus(32'h7000 + 32'(4 * i), 1'b1, 5'(10 + i), 1'b0, 1'b0, 5'b0, 2'b0,
                                32'h100 + 32'(i), 7'h0);
      #2 chk1($sformatf("t6_allowin%0d", i), ifc.ms_allowin, 1'b1);
      if (i > 0) begin
        chk1($sformatf("t6_valid%0d", i), ifc.ms_to_ws_valid, 1'b1);
        rpt($sformatf("t6_bus%0d", i), ifc.ms_to_ws_bus,
            exp_out(32'h7000 + 32'(4 * (i - 1)), 1'b1, 5'(9 + i), 32'h100 + 32'(i - 1), 7'h0));
      end
    end

    // Reset while a load waits, then a fresh load must complete normally
    nxt(); enter_load(32'h8000, 5'd2, LD_W, 2'd0);
    nxt(); ifc.es_to_ms_valid = 1'b0; resetn = 1'b0;
    nxt();
    #2 chk1("t7_rst_valid", ifc.ms_to_ws_valid, 1'b0);
    chk1("t7_rst_allowin", ifc.ms_allowin, 1'b1);
    rpt("t7_rst_collect", 77'(collect), 77'(0));
    resetn = 1'b1;
    nxt(); enter_load(32'h8004, 5'd2, LD_HU, 2'd2);
    nxt(); ifc.es_to_ms_valid = 1'b0; data_ok = 1'b1; rdata = 32'hCAFE_0001;
    #2 rpt("t7_after_rst_bus", ifc.ms_to_ws_bus, exp_out(32'h8004, 1'b1, 5'd2, 32'h0000_CAFE, 7'h0));
    nxt(); idle();

    // Randomized traffic against a transaction-level model
    out_pending = 1'b0;
    owner_live  = 1'b0;
    out_cnt     = 0;
    out_data    = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      nxt();
      dok            = out_pending && (out_cnt == 0);
      data_ok        = dok;
      rdata          = dok ? out_data : $urandom;
      ifc.ws_allowin = ($urandom_range(0, 3) != 0);
      flush          = ($urandom_range(0, 19) == 0);

      c.pc = $urandom; c.we = 1'($urandom_range(0, 1)); c.wa = 5'($urandom);
      c.exr = $urandom; c.al = 2'($urandom); c.data = $urandom;
      c.arrived = 1'b0; c.age = 0;
      case ($urandom_range(0, 4))
        0: c.op = LD_B;
        1: c.op = LD_BU;
        2: c.op = LD_H;
        3: c.op = LD_HU;
        default: c.op = LD_W;
      endcase
      c.exc = 7'h0; c.rfm = 1'b0; c.req = 1'b0;
      kind = $urandom_range(0, 9);
      if (kind < 4 && !out_pending) begin
        c.rfm = 1'b1; c.req = 1'b1;
      end else if (kind < 6 && !out_pending) begin
        c.req = 1'b1;
      end else if (kind == 6) begin
        c.exc = 7'($urandom_range(1, 127));
      end
      ifc.es_to_ms_valid = 1'($urandom_range(0, 1));
      ifc.es_to_ms_bus   = mk_bus(c.pc, c.we, c.wa, c.rfm, c.req, c.op, c.al, c.exr, c.exc);

      #2;
      e_has = (q.size() != 0);
      if (e_has) e = q[0];
      exp_rg = !e_has || !e.req || e.arrived || (dok && owner_live);
      exp_v  = e_has && exp_rg && !flush;
      exp_al = !e_has || (exp_rg && ifc.ws_allowin);
      chk1("rnd_valid", ifc.ms_to_ws_valid, exp_v);
      chk1("rnd_allowin", ifc.ms_allowin, exp_al);
      chk1("rnd_has_except", has_exc, e_has && (e.exc != 7'h0));
      rpt("rnd_collect_hi", 77'(collect[38:32]),
          77'({e_has && e.rfm && !exp_rg, e_has && e.we, e_has ? e.wa : 5'd0}));
      if (exp_v)
        rpt("rnd_bus", ifc.ms_to_ws_bus, exp_out(e.pc, e.we, e.wa, final_of(e), e.exc));
      if (e_has && exp_rg)
        chk32("rnd_fwd_result", collect[31:0], final_of(e));
      if (e_has && e.age > 40) begin
        rpt("rnd_timeout", 77'(e.age), 77'(40));
        break;
      end

      // Advance the model by one clock
      if (dok) begin
        out_pending = 1'b0;
        if (owner_live && q.size() != 0) q[0].arrived = 1'b1;
      end else if (out_pending) begin
        out_cnt--;
      end
      if (exp_v && ifc.ws_allowin) void'(q.pop_front());
      if (flush) begin
        q.delete();
        owner_live = 1'b0;
      end
      if (ifc.es_to_ms_valid && exp_al && !flush) begin
        q.push_back(c);
        if (c.req) begin
          out_pending = 1'b1;
          out_cnt     = $urandom_range(0, 3);
          out_data    = c.data;
          owner_live  = 1'b1;
        end
      end
      for (int i = 0; i < q.size(); i++) q[i].age++;
    end

    nxt(); idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
